mc_controller: RTL and testbench

- Multi-cycle control FSM for the 16-bit datapath; sits directly upstream of the ALU.
- Decodes the latched opcode and sequences FETCH/DECODE/EXEC/MEM/WB.
- Drives ALU select (alu_func), operand muxes, PC, IR, memory and register-file enables.
- Consumes the ALU zero flag to resolve BEQ.

---
 rtl/mc_controller.sv | 155 +++++++++++++++
 tb/tb_mc_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control FSM sequencing FETCH/DECODE/EXEC/MEM/WB for the 16-bit datapath
//   clk, rst_n       : rising-edge clock, synchronous active-low reset
//   opcode           : IR[15:12], valid from DECODE onward
//   zero, mem_ready  : ALU zero flag, memory access completes this cycle
//   pc_en, pc_src    : PC load enable and source select
//   i_or_d           : memory address select (0 PC, 1 ALUOut)
//   mem_read/write   : memory requests, held through stalls
//   ir_write         : IR load
//   reg_write/dst    : register-file write enable and destination select
//   mem_to_reg       : write-back source (1 MDR, 0 ALUOut)
//   alu_src_a/b      : ALU operand selects
//   alu_func         : ALU operation (ADD, SUB, AND, NOT)
//   state            : current state encoding
//   instr_done       : pulse in the retiring state of each instruction
//   illegal_op       : pulse in DECODE on an undefined opcode
//   instr_count      : retired-instruction count, wraps
module mc_controller #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           opcode,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 pc_en,
   output logic [1:0]           pc_src,
   output logic                 i_or_d,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic                 reg_write,
   output logic                 reg_dst,
   output logic                 mem_to_reg,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_func,
   output logic [3:0]           state,
   output logic                 instr_done,
   output logic                 illegal_op,
   output logic [CNT_WIDTH-1:0] instr_count
);
   typedef enum logic [3:0] {
      INIT, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
      MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP
   } state_t;
   state_t cur, nxt;
   logic pc_write, pc_write_cond;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur         <= INIT;
         instr_count <= '0;
      end else begin
         cur <= nxt;
         if (instr_done) instr_count <= instr_count + CNT_WIDTH'(1);
      end
   end
   always_comb begin
      nxt           = cur;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_func      = 2'b00;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      unique case (cur)
         INIT: nxt = FETCH;
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            nxt       = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            // branch target is computed here so BRANCH can use ALUOut
            alu_src_b  = 2'b11;
            illegal_op = opcode > 4'd8;
            nxt = opcode <= 4'd3 ? EXEC_R :
                  opcode == 4'd4 ? EXEC_I :
                  (opcode == 4'd5 || opcode == 4'd6) ? MEM_ADDR :
                  opcode == 4'd7 ? BRANCH :
                  opcode == 4'd8 ? JUMP : FETCH;
         end
         EXEC_R: begin
            alu_src_a = 1'b1;
            alu_func  = opcode[1:0];
            nxt       = WB_R;
         end
         WB_R: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt       = WB_I;
         end
         WB_I: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt       = opcode == 4'd6 ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            nxt      = mem_ready ? WB_MEM : MEM_RD;
         end
         WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         MEM_WR: begin
            mem_write  = 1'b1;
            i_or_d     = 1'b1;
            instr_done = mem_ready;
            nxt        = mem_ready ? FETCH : MEM_WR;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_func      = 2'b01;
            pc_write_cond = 1'b1;
            pc_src        = 2'b01;
            instr_done    = 1'b1;
            nxt           = FETCH;
         end
         JUMP: begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         default: nxt = INIT;
      endcase
   end
   assign pc_en = pc_write | (pc_write_cond & zero);
   assign state = cur;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized instruction-level checking of mc_controller against a sequence model
module tb_mc_controller;
   logic clk = 1'b0, rst_n, zero, mem_ready;
   logic [3:0] opcode, state;
   logic pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, instr_done, illegal_op;
   logic [1:0] pc_src, alu_src_b, alu_func, instr_count;
   int tests = 0, fails = 0, cyc = 0;
   logic [1:0] m_count;

   typedef struct packed {
      logic [3:0]  s;
      logic [16:0] o;
      logic [1:0]  c;
   } exp_t;
   exp_t q[$];

   mc_controller #(.CNT_WIDTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_func(alu_func), .state(state),
      .instr_done(instr_done), .illegal_op(illegal_op), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
      end
   endtask

   // expected control outputs for a state, taken straight from the output table
   function automatic logic [16:0] exp_out(input logic [3:0] s, input logic [3:0] op, input logic mr, input logic z);
      logic pe, ird, mrd, mwr, irw, rw, rd, m2r, sa, done, ill;
      logic [1:0] ps, sb, f;
      {pe, ird, mrd, mwr, irw, rw, rd, m2r, sa, done, ill} = '0;
      {ps, sb, f} = '0;
      case (s)
         4'd1: begin mrd = 1; sb = 2'b01; irw = mr; pe = mr; end
         4'd2: begin sb = 2'b11; ill = op > 8; end
         4'd3: begin sa = 1; f = op[1:0]; end
         4'd4: begin rw = 1; rd = 1; done = 1; end
         4'd5, 4'd7: begin sa = 1; sb = 2'b10; end
         4'd6: begin rw = 1; done = 1; end
         4'd8: begin mrd = 1; ird = 1; end
         4'd9: begin rw = 1; m2r = 1; done = 1; end
         4'd10: begin mwr = 1; ird = 1; done = mr; end
         4'd11: begin sa = 1; f = 2'b01; ps = 2'b01; pe = z; done = 1; end
         4'd12: begin pe = 1; ps = 2'b10; done = 1; end
         default: ;
      endcase
      return {pe, ps, ird, mrd, mwr, irw, rw, rd, m2r, sa, sb, f, done, ill};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // one clock cycle: drive inputs, queue what the DUT must show this cycle, advance the model counter
   task automatic step(input logic [3:0] s, input logic mr, input logic z, input logic r);
      exp_t e;
      rst_n = r;
      mem_ready = mr;
      zero = z;
      e.s = s;
      e.o = exp_out(s, opcode, mr, z);
      e.c = m_count;
      q.push_back(e);
      if (!r) m_count = 0;
      else if (e.o[1]) m_count = m_count + 2'd1;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // expected state path of one whole instruction with the given stall counts
   task automatic run_instr(input logic [3:0] op, input int fs, input int ms, input logic z, output int n);
      int c0;
      c0 = cyc;
      opcode = op;
      repeat (fs) step(4'd1, 1'b0, rb(), 1'b1);
      step(4'd1, 1'b1, rb(), 1'b1);
      step(4'd2, rb(), rb(), 1'b1);
      if (op <= 3) begin
         step(4'd3, rb(), rb(), 1'b1);
         step(4'd4, rb(), rb(), 1'b1);
      end else if (op == 4) begin
         step(4'd5, rb(), rb(), 1'b1);
         step(4'd6, rb(), rb(), 1'b1);
      end else if (op == 5) begin
         step(4'd7, rb(), rb(), 1'b1);
         repeat (ms) step(4'd8, 1'b0, rb(), 1'b1);
         step(4'd8, 1'b1, rb(), 1'b1);
         step(4'd9, rb(), rb(), 1'b1);
      end else if (op == 6) begin
         step(4'd7, rb(), rb(), 1'b1);
         repeat (ms) step(4'd10, 1'b0, rb(), 1'b1);
         step(4'd10, 1'b1, rb(), 1'b1);
      end else if (op == 7) step(4'd11, rb(), z, 1'b1);
      else if (op == 8) step(4'd12, rb(), rb(), 1'b1);
      n = cyc - c0;
   endtask

   task automatic do_reset();
      step(4'd1, 1'b0, rb(), 1'b0);
      step(4'd0, rb(), rb(), 1'b1);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("state", 32'(state), 32'(e.s));
         chk("outputs", 32'({pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst,
                             mem_to_reg, alu_src_a, alu_src_b, alu_func, instr_done, illegal_op}), 32'(e.o));
         chk("instr_count", 32'(instr_count), 32'(e.c));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic [3:0] op;
      logic [1:0] jexp [5];
      jexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      rst_n = 1'b0;
      mem_ready = 1'b0;
      zero = 1'b0;
      opcode = 4'd0;
      m_count = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 32'(state), 32'd0);
      step(4'd0, rb(), rb(), 1'b1);
      run_instr(4'hF, 0, 0, 1'b0, n);
      chk("illegal_latency", n, 2);
      chk("illegal_count", 32'(instr_count), 32'd0);
      for (int i = 0; i < 5; i++) begin
         run_instr(4'd8, 0, 0, 1'b0, n);
         chk("j_latency", n, 3);
         chk("j_count", 32'(instr_count), 32'(jexp[i]));
      end
      run_instr(4'd0, 0, 0, 1'b0, n);
      chk("add_latency", n, 4);
      chk("add_end_state", 32'(state), 32'd1);
      run_instr(4'd5, 0, 3, 1'b0, n);
      chk("lw_stall_latency", n, 8);
      run_instr(4'd7, 0, 0, 1'b1, n);
      chk("beq_taken_latency", n, 3);
      run_instr(4'd7, 0, 0, 1'b0, n);
      chk("beq_not_taken_latency", n, 3);
      run_instr(4'd6, 0, 0, 1'b0, n);
      chk("sw_latency", n, 4);
      run_instr(4'd4, 0, 0, 1'b0, n);
      chk("addi_latency", n, 4);
      opcode = 4'd6;
      step(4'd1, 1'b1, rb(), 1'b1);
      step(4'd2, rb(), rb(), 1'b1);
      step(4'd7, rb(), rb(), 1'b1);
      step(4'd10, 1'b0, rb(), 1'b1);
      step(4'd10, 1'b1, rb(), 1'b0);
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_count", 32'(instr_count), 32'd0);
      step(4'd0, rb(), rb(), 1'b1);
      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 10));
         if (op > 8) op = 4'($urandom_range(9, 15));
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb(), n);
         if ($urandom_range(0, 39) == 0) do_reset();
      end
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
